// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: FSM encoding, access-size codes and the
// captured request record.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StFault  = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    MemByte = 2'b00,
    MemHalf = 2'b01,
    MemWord = 2'b10
  } mem_size_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] sdata;
    mem_size_e   size;
    logic        uns;
    logic        we;
    logic [4:0]  rd;
    logic        regwrite;
  } mem_req_t;

  // Byte accesses are always aligned; the unused size code is treated as a word.
  function automatic logic addr_aligned(input mem_size_e size, input logic [1:0] lo);
    logic ok;
    case (size)
      MemByte: ok = 1'b1;
      MemHalf: ok = ~lo[0];
      default: ok = (lo == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering: store strobes/replication, load extraction and
// the alignment check.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  mem_size_e   size_i,
  input  logic        unsigned_i,
  input  logic [31:0] storedata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] loaddata_o,
  output logic        aligned_o
);

  logic [31:0] lane;

  always_comb begin
    lane       = rdata_i >> {addr_lo_i, 3'b000};
    aligned_o  = addr_aligned(size_i, addr_lo_i);
    wstrb_o    = 4'b1111;
    wdata_o    = storedata_i;
    loaddata_o = rdata_i;
    case (size_i)
      MemByte: begin
        wstrb_o    = 4'b0001 << addr_lo_i;
        wdata_o    = {4{storedata_i[7:0]}};
        loaddata_o = {{24{~unsigned_i & lane[7]}}, lane[7:0]};
      end
      MemHalf: begin
        wstrb_o    = 4'b0011 << addr_lo_i;
        wdata_o    = {2{storedata_i[15:0]}};
        loaddata_o = {{16{~unsigned_i & lane[15]}}, lane[15:0]};
      end
      default: begin
        wstrb_o    = 4'b1111;
        wdata_o    = storedata_i;
        loaddata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues data-memory accesses, stalls the front end while
// waiting for dmem_ack, and fills the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] aluresult,
  input  logic [31:0] storedata,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  memsize,
  input  logic        memunsigned,
  input  logic        regwrite,
  input  logic [4:0]  rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic        wb_regwrite,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        mem_fault
);

  localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 6) ? $clog2(TIMEOUT + 1) : 6;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  mem_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  mem_req_t        req_in, req_q, cur;

  logic        is_mem, aligned, req_go, done;
  logic [3:0]  strb;
  logic [31:0] wdata, ldata;

  logic        wb_valid_d, wb_regwrite_d;
  logic [4:0]  wb_rd_d;
  logic [31:0] wb_data_d;

  // The instruction is captured while IDLE so ACCESS drives a frozen copy.
  always_comb begin
    req_in.addr     = aluresult;
    req_in.sdata    = storedata;
    req_in.size     = mem_size_e'(memsize);
    req_in.uns      = memunsigned;
    req_in.we       = memwrite;
    req_in.rd       = rd;
    req_in.regwrite = regwrite;
    cur             = (state_q == StAccess) ? req_q : req_in;
    is_mem          = ex_valid & (memread | memwrite);
  end

  mem_align u_align (
    .addr_lo_i   (cur.addr[1:0]),
    .size_i      (cur.size),
    .unsigned_i  (cur.uns),
    .storedata_i (cur.sdata),
    .rdata_i     (dmem_rdata),
    .wstrb_o     (strb),
    .wdata_o     (wdata),
    .loaddata_o  (ldata),
    .aligned_o   (aligned)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (is_mem) begin
          if (!aligned) begin
            state_d = StFault;
          end else if (!dmem_ack) begin
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        if (dmem_ack) begin
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          state_d = StFault;
        end
      end
      StFault: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic; reset masks the combinational paths from the EX/MEM inputs.
  always_comb begin
    req_go     = ((state_q == StIdle) & is_mem & aligned) | (state_q == StAccess);
    done       = req_go & dmem_ack;
    dmem_req   = ~reset & req_go;
    dmem_we    = dmem_req & cur.we;
    dmem_wstrb = dmem_we ? strb : 4'b0000;
    dmem_addr  = {cur.addr[31:2], 2'b00};
    dmem_wdata = wdata;
    mem_stall  = ~reset & (((state_q == StIdle) & is_mem & ~(aligned & dmem_ack)) |
                           ((state_q == StAccess) & ~dmem_ack));
    mem_fault  = ~reset & (state_q == StFault);
  end

  // MEM/WB next value: ALU results and completed loads; everything else is a bubble.
  always_comb begin
    wb_valid_d    = 1'b0;
    wb_regwrite_d = 1'b0;
    wb_rd_d       = '0;
    wb_data_d     = '0;
    if ((state_q == StIdle) && ex_valid && !(memread || memwrite)) begin
      wb_valid_d    = 1'b1;
      wb_regwrite_d = regwrite;
      wb_rd_d       = rd;
      wb_data_d     = aluresult;
    end else if (done && !cur.we) begin
      wb_valid_d    = 1'b1;
      wb_regwrite_d = cur.regwrite;
      wb_rd_d       = cur.rd;
      wb_data_d     = ldata;
    end
  end

  always_comb begin
    cnt_d = (state_q == StAccess) ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      req_q       <= '0;
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      if (state_q == StIdle) begin
        req_q <= req_in;
      end
      wb_valid    <= wb_valid_d;
      wb_regwrite <= wb_regwrite_d;
      wb_rd       <= wb_rd_d;
      wb_data     <= wb_data_d;
    end
  end

endmodule
